// File: rtl/instr_loader.sv
// Boot-time program loader: receives a framed byte stream, writes 16-bit words to
// instruction memory at byte addresses 0, 2, 4, ... and holds the core until a frame
// with a good checksum has loaded.
module instr_loader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_WORDS  = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] words_loaded
);

    // Counter compare width: wide enough for both the 16-bit length and words_loaded + 1.
    localparam int unsigned CntW = (ADDR_WIDTH > 16) ? ADDR_WIDTH + 1 : 17;

    typedef enum logic [3:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            chk_q, chk_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] words_q, words_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    logic            accept;
    logic [15:0]     len_in;
    logic [CntW-1:0] words_next;
    logic [CntW-1:0] len_ext;

    assign accept     = in_valid & in_ready;
    // Full length as it becomes known while the low length byte is being accepted.
    assign len_in     = {len_q[15:8], in_data};
    assign words_next = CntW'(words_q) + CntW'(1);
    assign len_ext    = CntW'(len_q);

    assign mem_addr     = addr_q;
    assign mem_wr_data  = word_q;
    assign words_loaded = words_q;

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        chk_d     = chk_q;
        addr_d    = addr_q;
        words_d   = words_q;
        word_d    = word_q;
        in_ready  = (state_q != StWrite);
        mem_wr_en = (state_q == StWrite);
        done      = (state_q == StDone);
        error     = (state_q == StError);
        cpu_hold  = (state_q != StDone);

        unique case (state_q)
            // Sync hunt; a new sync byte also restarts after a finished or rejected frame.
            StIdle, StDone, StError: begin
                if (accept && in_data == 8'hA5) begin
                    state_d = StLenHi;
                    chk_d   = 8'h00;
                    addr_d  = '0;
                    words_d = '0;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    chk_d       = chk_q + in_data;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    chk_d      = chk_q + in_data;
                    if (len_in == 16'd0 || 32'(len_in) > MAX_WORDS) begin
                        state_d = StError;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (accept) begin
                    word_d[15:8] = in_data;
                    chk_d        = chk_q + in_data;
                    state_d      = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    word_d[7:0] = in_data;
                    chk_d       = chk_q + in_data;
                    state_d     = StWrite;
                end
            end
            // Single write cycle; input is stalled so the next byte waits here.
            StWrite: begin
                addr_d  = addr_q + ADDR_WIDTH'(2);
                words_d = words_q + ADDR_WIDTH'(1);
                if (words_next == len_ext) begin
                    state_d = StCheck;
                end else begin
                    state_d = StDataHi;
                end
            end
            StCheck: begin
                if (accept) begin
                    chk_d = chk_q + in_data;
                    if (chk_d == 8'h00) begin
                        state_d = StDone;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            chk_q   <= '0;
            addr_q  <= '0;
            words_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a write scoreboard.
module tb_instr_loader;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW-1:0] words_loaded;

    instr_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    int  n_stalls = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write must match the next expected (addr, data).
    always @(negedge clk) begin
        wr_t e;
        if (in_ready === 1'b0) n_stalls++;
        if (mem_wr_en === 1'b1) begin
            n_writes++;
            check("wr_stall", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.a));
                check("wr_data", 32'(mem_wr_data), 32'(e.d));
            end
        end
    end

    function automatic logic [15:0] word_of(input int seed, input int i);
        if (seed == 0) return (i == 0) ? 16'h1234 : 16'hABCD;
        return 16'(seed * 4369 + i * 855 + (i >> 3));
    endfunction

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Full frame with checksum chosen so the post-sync sum is zero (plus one if bad).
    task automatic send_frame(input int n, input int seed, input bit bad);
        logic [15:0] nn;
        logic [15:0] w;
        logic [7:0]  sum;
        nn  = 16'(n);
        sum = 8'h00;
        send(8'hA5);
        send(nn[15:8]);
        sum = sum + nn[15:8];
        send(nn[7:0]);
        sum = sum + nn[7:0];
        for (int i = 0; i < n; i++) begin
            w = word_of(seed, i);
            exp_q.push_back('{a: AW'(2 * i), d: w});
            send(w[15:8]);
            send(w[7:0]);
            sum = sum + w[15:8] + w[7:0];
            if (i < 4) check("wr_latency", 32'(mem_wr_en), 32'd1);
        end
        send(8'(8'h00 - sum) + (bad ? 8'h01 : 8'h00));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wr_data), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        int wr_before;
        logic [15:0] w;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Normal frame: A5 00 02 12 34 AB CD, checksum byte 0x40.
        send_frame(2, 0, 1'b0);
        idle();
        check("normal_done", 32'(done), 32'd1);
        check("normal_hold", 32'(cpu_hold), 32'd0);
        check("normal_error", 32'(error), 32'd0);
        check("normal_words", 32'(words_loaded), 32'd2);
        check("normal_addr", 32'(mem_addr), 32'd4);
        check("normal_sb_empty", 32'(exp_q.size()), 32'd0);

        // Non-sync byte in DONE is ignored.
        send(8'h00);
        idle();
        check("done_ignore", 32'(done), 32'd1);

        // Bad checksum: writes still land, frame rejected.
        send_frame(2, 0, 1'b1);
        idle();
        check("badchk_error", 32'(error), 32'd1);
        check("badchk_done", 32'(done), 32'd0);
        check("badchk_hold", 32'(cpu_hold), 32'd1);
        check("badchk_words", 32'(words_loaded), 32'd2);
        check("badchk_sb_empty", 32'(exp_q.size()), 32'd0);

        // Recovery from ERROR with a valid 3-word frame.
        send_frame(3, 7, 1'b0);
        idle();
        check("recover_done", 32'(done), 32'd1);
        check("recover_error", 32'(error), 32'd0);
        check("recover_words", 32'(words_loaded), 32'd3);

        // Illegal lengths: zero and MAX_WORDS+1.
        wr_before = n_writes;
        send(8'hA5); send(8'h00); send(8'h00);
        check("len0_error", 32'(error), 32'd1);
        check("len0_done", 32'(done), 32'd0);
        check("len0_hold", 32'(cpu_hold), 32'd1);
        send(8'hA5); send(8'h08); send(8'h01);
        idle();
        check("len2049_error", 32'(error), 32'd1);
        check("badlen_no_write", 32'(n_writes), 32'(wr_before));

        // Largest legal frame: last word at 0xFFE.
        send_frame(2048, 3, 1'b0);
        idle();
        check("max_done", 32'(done), 32'd1);
        check("max_words", 32'(words_loaded), 32'd2048);
        check("max_sb_empty", 32'(exp_q.size()), 32'd0);

        // Sync hunt from IDLE.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(8'h00); send(8'hFF); send(8'h5A);
        idle();
        check_idle_outputs("hunt");
        send_frame(2, 0, 1'b0);
        idle();
        check("hunt_done", 32'(done), 32'd1);
        check("hunt_words", 32'(words_loaded), 32'd2);

        // Back-to-back stream: exactly one stall cycle per word.
        n_stalls  = 0;
        wr_before = n_writes;
        send_frame(4, 11, 1'b0);
        idle();
        check("bp_done", 32'(done), 32'd1);
        check("bp_writes", 32'(n_writes - wr_before), 32'd4);
        check("bp_stalls", 32'(n_stalls), 32'd4);

        // Sync byte while in DONE restarts the frame.
        send(8'hA5);
        idle();
        check("restart_done", 32'(done), 32'd0);
        check("restart_hold", 32'(cpu_hold), 32'd1);
        check("restart_words", 32'(words_loaded), 32'd0);

        // Reset while in DATA_LO of word 2 of a 4-word frame.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(8'hA5); send(8'h00); send(8'h04);
        w = word_of(5, 0);
        exp_q.push_back('{a: AW'(0), d: w});
        send(w[15:8]); send(w[7:0]);
        w = word_of(5, 1);
        send(w[15:8]);
        check("mid_words_before", 32'(words_loaded), 32'd1);
        check("mid_addr_before", 32'(mem_addr), 32'd2);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        #1 check_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_sb_empty", 32'(exp_q.size()), 32'd0);
        check_idle_outputs("after_reset");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
